multicycle_control_fsm: RTL and testbench

- Control unit for the multicycle variant of the RV32I core. It replaces per-instruction combinational decode with a state machine that sequences fetch, decode, execute, memory and writeback over several cycles.
- All steps share one ALU and one unified instruction/data memory port.
- Sits between the instruction register / ALU zero flag and the multicycle datapath muxes, register file, PC and memory.
- Supports lw, sw, R-type, addi, beq, jal, lui.

---
 rtl/multicycle_control_fsm.sv | 167 ++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback over a shared ALU and memory port.
// Latency 3-5 cycles per instruction; stalls in FETCH, MEMREAD and MEMWRITE while mem_ready=0.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic       reg_write,
  output logic       illegal_instr,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'd3;
  localparam logic [6:0] OP_SW   = 7'd35;
  localparam logic [6:0] OP_R    = 7'd51;
  localparam logic [6:0] OP_I    = 7'd19;
  localparam logic [6:0] OP_BEQ  = 7'd99;
  localparam logic [6:0] OP_JAL  = 7'd111;
  localparam logic [6:0] OP_LUI  = 7'd55;

  state_t state_q;
  state_t state_d;
  logic   pc_update;
  logic   branch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC+4 computed by the ALU is routed straight to the PC
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_update = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          OP_LUI:       state_d = S_LUI;
          default: begin
            illegal_instr = 1'b1;
            state_d       = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        if (opcode == OP_LW)      state_d = S_MEMREAD;
        else if (opcode == OP_SW) state_d = S_MEMWRITE;
        else                      state_d = S_FETCH;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        // ALUOut holds the target from DECODE; ALU meanwhile forms OldPC+4 for rd
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign pc_write = pc_update | (branch & zero);
  assign state_o  = state_q;

  always_comb begin
    case (opcode)
      OP_SW:   imm_src = 3'b001;
      OP_BEQ:  imm_src = 3'b010;
      OP_JAL:  imm_src = 3'b011;
      OP_LUI:  imm_src = 3'b100;
      default: imm_src = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed vector table, reset corner case, then random instruction stream
// checked against an instruction-level model (latency, strobe counts, immediate type).
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src;
  logic [3:0] state_o;

  int vectors = 0;
  int miscompares = 0;

  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_src(imm_src), .reg_write(reg_write), .illegal_instr(illegal_instr), .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [6:0]  op;
    logic        z;
    logic        rdy;
    logic [20:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [2:0] exp_imm(input int op);
    case (op)
      35:      return 3'b001;
      99:      return 3'b010;
      111:     return 3'b011;
      55:      return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [20:0] mk(input int op, input int st, input int pcw, input int irw,
                                     input int rw, input int mw, input int ill, input int adr,
                                     input int rs, input int a, input int b, input int aop);
    return {4'(st), 1'(pcw), 1'(irw), 1'(rw), 1'(mw), 1'(ill), 1'(adr),
            2'(rs), 2'(a), 2'(b), 2'(aop), exp_imm(op)};
  endfunction

  function automatic logic [20:0] actual();
    return {state_o, pc_write, ir_write, reg_write, mem_write, illegal_instr, adr_src,
            result_src, alu_src_a, alu_src_b, alu_op, imm_src};
  endfunction

  task automatic add(input int op, input int z, input int rdy, input int st, input int pcw,
                     input int irw, input int rw, input int mw, input int ill, input int adr,
                     input int rs, input int a, input int b, input int aop);
    vec_t v;
    v.op  = 7'(op);
    v.z   = 1'(z);
    v.rdy = 1'(rdy);
    v.exp = mk(op, st, pcw, irw, rw, mw, ill, adr, rs, a, b, aop);
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    return op == 7'd3 || op == 7'd35 || op == 7'd51 || op == 7'd19 ||
           op == 7'd99 || op == 7'd111 || op == 7'd55;
  endfunction

  initial begin
    int unsigned legal_ops [7] = '{3, 35, 51, 19, 99, 111, 55};

    rst_n = 1'b0; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(actual()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0)));
    rst_n = 1'b1;

    // op z rdy | st pcw irw rw mw ill adr rs a b aop
    add(51, 0, 1,  0, 1, 1, 0, 0, 0, 0, 2, 0, 2, 0);
    add(51, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    add(51, 0, 1,  6, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2);
    add(51, 0, 1,  8, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add( 3, 0, 0,  0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0);
    add( 3, 0, 0,  0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0);
    add( 3, 0, 1,  0, 1, 1, 0, 0, 0, 0, 2, 0, 2, 0);
    add( 3, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    add( 3, 0, 1,  2, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0);
    add( 3, 0, 0,  3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add( 3, 0, 0,  3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add( 3, 0, 0,  3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add( 3, 0, 1,  3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add( 3, 0, 1,  4, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    add(99, 1, 1,  0, 1, 1, 0, 0, 0, 0, 2, 0, 2, 0);
    add(99, 1, 1,  1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    add(99, 1, 1,  9, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1);
    add(99, 0, 1,  0, 1, 1, 0, 0, 0, 0, 2, 0, 2, 0);
    add(99, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    add(99, 0, 1,  9, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1);
    add(111,0, 1,  0, 1, 1, 0, 0, 0, 0, 2, 0, 2, 0);
    add(111,0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    add(111,0, 1, 10, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0);
    add(111,0, 1,  8, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(127,0, 1,  0, 1, 1, 0, 0, 0, 0, 2, 0, 2, 0);
    add(127,0, 1,  1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    add(35, 0, 1,  0, 1, 1, 0, 0, 0, 0, 2, 0, 2, 0);
    add(35, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    add(35, 0, 1,  2, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0);
    add(35, 0, 0,  5, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    add(35, 0, 1,  5, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    add(55, 0, 1,  0, 1, 1, 0, 0, 0, 0, 2, 0, 2, 0);
    add(55, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    add(55, 0, 1, 11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    add(55, 0, 1,  8, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(19, 0, 1,  0, 1, 1, 0, 0, 0, 0, 2, 0, 2, 0);
    add(19, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    add(19, 0, 1,  7, 0, 0, 0, 0, 0, 0, 0, 2, 1, 2);
    add(19, 0, 1,  8, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(51, 0, 0,  0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      opcode = tbl[i].op; zero = tbl[i].z; mem_ready = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(actual()), 32'(tbl[i].exp));
      @(posedge clk);
      #1;
    end

    // Reset asserted mid-MEMREAD and released between edges
    opcode = 7'd3; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_reset_memread", 32'(state_o), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 32'(actual()), 32'(mk(3, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0)));
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("post_reset%0d", i), 32'(actual()), 32'(mk(3, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0)));
      @(posedge clk); #1;
    end

    // Random instruction stream against an instruction-level model
    for (int n = 0; n < 250; n++) begin
      logic [6:0] op;
      bit z, is_mem;
      int nf, nm, total, base;
      int c_rw, c_mw, c_pcw, c_irw, c_ill, c_fetch;
      int e_rw, e_mw, e_pcw, e_ill;

      if ($urandom_range(0, 7) == 7) begin
        do op = 7'($urandom); while (is_legal(op));
      end else begin
        op = 7'(legal_ops[$urandom_range(0, 6)]);
      end
      z  = 1'($urandom_range(0, 1));
      nf = $urandom_range(0, 2);
      nm = $urandom_range(0, 3);
      is_mem = (op == 7'd3 || op == 7'd35);
      case (op)
        7'd3:    base = 5;
        7'd99:   base = 3;
        7'd35, 7'd51, 7'd19, 7'd55, 7'd111: base = 4;
        default: base = 2;
      endcase
      if (!is_mem) nm = 0;
      total = base + nf + nm;
      e_rw  = (op == 7'd3 || op == 7'd51 || op == 7'd19 || op == 7'd55 || op == 7'd111) ? 1 : 0;
      e_mw  = (op == 7'd35) ? nm + 1 : 0;
      e_pcw = 1 + ((op == 7'd111) ? 1 : 0) + ((op == 7'd99 && z) ? 1 : 0);
      e_ill = is_legal(op) ? 0 : 1;

      c_rw = 0; c_mw = 0; c_pcw = 0; c_irw = 0; c_ill = 0; c_fetch = 0;
      for (int k = 0; k < total; k++) begin
        opcode = op; zero = z;
        if (k < nf)                                         mem_ready = 1'b0;
        else if (k == nf)                                   mem_ready = 1'b1;
        else if (is_mem && k >= nf + 3 && k < nf + 3 + nm)  mem_ready = 1'b0;
        else if (is_mem && k == nf + 3 + nm)                mem_ready = 1'b1;
        else                                                mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (k == 0) check($sformatf("rnd%0d_start", n), 32'(state_o), 32'd0);
        check($sformatf("rnd%0d_imm", n), 32'(imm_src), 32'(exp_imm(int'(op))));
        c_rw    += int'(reg_write);
        c_mw    += int'(mem_write);
        c_pcw   += int'(pc_write);
        c_irw   += int'(ir_write);
        c_ill   += int'(illegal_instr);
        c_fetch += (state_o == 4'd0) ? 1 : 0;
        @(posedge clk); #1;
      end
      check($sformatf("rnd%0d_op%0d_fetch_cycles", n, op), 32'(c_fetch), 32'(nf + 1));
      check($sformatf("rnd%0d_op%0d_reg_write", n, op), 32'(c_rw), 32'(e_rw));
      check($sformatf("rnd%0d_op%0d_mem_write", n, op), 32'(c_mw), 32'(e_mw));
      check($sformatf("rnd%0d_op%0d_pc_write", n, op), 32'(c_pcw), 32'(e_pcw));
      check($sformatf("rnd%0d_op%0d_ir_write", n, op), 32'(c_irw), 32'd1);
      check($sformatf("rnd%0d_op%0d_illegal", n, op), 32'(c_ill), 32'(e_ill));
    end
    @(negedge clk);
    check("final_fetch", 32'(state_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
